otter_cu_fsm: RTL
=================

// Module: otter_cu_fsm
// PURPOSE
// - Multicycle control-unit state machine for the OTTER core; consumes the instruction word
//   returned by the fetch stage (PC + PC mux + instruction memory port 1).
// - Sequences INIT/FETCH/EXEC/WRITEBACK and drives PC_WRITE and MEM_READ1 back into the
//   fetch stage, plus the register-file and data-memory strobes for the downstream stages.
// PARAMETERS
// - LOAD_WAIT  default 1  extra cycles spent in WB before a load result is written (0..15)
// PORTS
// - CLK         in   1  core clock; all state changes on rising edge
// - RESET       in   1  synchronous, active-high reset
// - OPCODE      in   7  instruction bits [6:0] from fetch DOUT
// - INTR        in   1  external interrupt request (used only with OTTER_INTR_EN)
// - RST         out  1  reset strobe to PC and register file
// - MEM_READ1   out  1  instruction-memory read enable (fetch)
// - PC_WRITE    out  1  PC load enable
// - REG_WRITE   out  1  register-file write enable
// - MEM_WE2     out  1  data-memory write enable (store)
// - MEM_RDEN2   out  1  data-memory read enable (load)
// - INTR_TAKEN  out  1  interrupt-entry strobe (held 0 without OTTER_INTR_EN)
// - ILLEGAL     out  1  one-cycle pulse in EXEC for an undecoded opcode
// BEHAVIOUR
// - States: ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR; 3-bit encoding, registered state.
// - RESET=1 at an edge -> ST_INIT next cycle, from any state, aborting any operation.
// - Outputs are combinational from state and OPCODE; all outputs are 0 unless listed below.
// - ST_INIT: RST=1. Next: ST_FETCH (once RESET is low).
// - ST_FETCH: MEM_READ1=1. Next: ST_EXEC (1-cycle memory; OPCODE valid in EXEC).
// - ST_EXEC, decoded by OPCODE:
//   - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP_IMM 0010011, OP 0110011,
//     SYSTEM 1110011: PC_WRITE=1, REG_WRITE=1
//   - BRANCH 1100011: PC_WRITE=1
//   - STORE 0100011: PC_WRITE=1, MEM_WE2=1
//   - LOAD 0000011: MEM_RDEN2=1, PC_WRITE=0; next ST_WB
//   - any other opcode: PC_WRITE=1, ILLEGAL=1; no register or memory write
//   - Next state for all non-LOAD cases: ST_FETCH (or ST_INTR, see CONFIGURATION).
// - ST_WB:
//   - 4-bit wait counter loaded with LOAD_WAIT on entry; decrements each cycle.
//   - While the counter is nonzero, all outputs are 0.
//   - At 0: REG_WRITE=1, PC_WRITE=1; next ST_FETCH (or ST_INTR).
//   - LOAD_WAIT=0: single WB cycle that writes immediately.
// - Every instruction produces exactly one PC_WRITE pulse.
// - REG_WRITE and MEM_WE2 are never high in the same cycle.
// - RESET mid-WB: the counter is cleared and no REG_WRITE is issued.
// CONFIGURATION
// - Macro OTTER_INTR_EN.
// - Defined:
//   - INTR is sampled on the last cycle of an instruction (non-load EXEC, or WB at count 0).
//   - If INTR=1, next state is ST_INTR instead of ST_FETCH.
//   - ST_INTR: INTR_TAKEN=1, PC_WRITE=1; next ST_FETCH.
//   - A 1-bit in-service flag set on entry to ST_INTR masks INTR until the next RESET.
//   - INTR asserted during FETCH or a mid-WB cycle is held by the sampling point, not latched.
// - Undefined: INTR is ignored, ST_INTR is unreachable, INTR_TAKEN is tied 0.
// TESTING
// - RESET=1 for 2 cycles, then 0 -> RST=1 in INIT; first MEM_READ1=1 one cycle after
//   RESET falls.
// - OPCODE=0110011 -> FETCH,EXEC repeat; PC_WRITE and REG_WRITE high in EXEC only,
//   period 2 cycles.
// - OPCODE=0000011, LOAD_WAIT=2 -> EXEC with MEM_RDEN2=1, WB 0-0-write; REG_WRITE and
//   PC_WRITE on the 3rd WB cycle; 5 cycles per instruction.
// - OPCODE=0100011 -> MEM_WE2=1 and PC_WRITE=1 in EXEC, REG_WRITE=0 throughout.
//   OPCODE=1111111 -> ILLEGAL=1 pulse, PC_WRITE=1.
// - RESET asserted in the 1st WB cycle of a load -> INIT next cycle; REG_WRITE never
//   asserted for that load.
// - OTTER_INTR_EN, INTR=1 during OP EXEC -> next cycle INTR_TAKEN=1, PC_WRITE=1, then FETCH.
//   A second INTR is ignored until RESET.

Source files
------------

// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: multicycle OTTER control unit (INIT/FETCH/EXEC/WB, optional INTR state)
// Define OTTER_INTR_EN to enable interrupt entry; otherwise INTR is ignored and INTR_TAKEN is 0.
module otter_cu_fsm #(
    parameter int LOAD_WAIT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] OPCODE,
    input  logic       INTR,
    output logic       RST,
    output logic       MEM_READ1,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_WE2,
    output logic       MEM_RDEN2,
    output logic       INTR_TAKEN,
    output logic       ILLEGAL
);
    typedef enum logic [2:0] {ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR} state_t;
    state_t state, nxt, done_nxt;
    logic [3:0] cnt;
`ifdef OTTER_INTR_EN
    logic in_svc;
    assign done_nxt = (INTR && !in_svc) ? ST_INTR : ST_FETCH;
`else
    logic unused_intr;
    assign unused_intr = INTR;
    assign done_nxt = ST_FETCH;
`endif
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_INIT;
            cnt <= 4'd0;
        end else begin
            state <= nxt;
            cnt <= (state == ST_EXEC) ? 4'(LOAD_WAIT) : cnt - 4'(cnt != 4'd0);
        end
    end
`ifdef OTTER_INTR_EN
    // The in-service flag masks further interrupts until the next reset.
    always_ff @(posedge CLK) begin
        if (RESET) in_svc <= 1'b0;
        else if (nxt == ST_INTR) in_svc <= 1'b1;
    end
`endif
    always_comb begin
        nxt = state;
        RST = 1'b0;
        MEM_READ1 = 1'b0;
        PC_WRITE = 1'b0;
        REG_WRITE = 1'b0;
        MEM_WE2 = 1'b0;
        MEM_RDEN2 = 1'b0;
        INTR_TAKEN = 1'b0;
        ILLEGAL = 1'b0;
        case (state)
            ST_INIT: begin
                RST = 1'b1;
                nxt = ST_FETCH;
            end
            ST_FETCH: begin
                MEM_READ1 = 1'b1;
                nxt = ST_EXEC;
            end
            ST_EXEC: begin
                PC_WRITE = 1'b1;
                nxt = done_nxt;
                case (OPCODE)
                    7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                    7'b0010011, 7'b0110011, 7'b1110011: REG_WRITE = 1'b1;
                    7'b1100011: ;
                    7'b0100011: MEM_WE2 = 1'b1;
                    7'b0000011: begin
                        PC_WRITE = 1'b0;
                        MEM_RDEN2 = 1'b1;
                        nxt = ST_WB;
                    end
                    default: ILLEGAL = 1'b1;
                endcase
            end
            ST_WB: begin
                REG_WRITE = cnt == 4'd0;
                PC_WRITE = cnt == 4'd0;
                nxt = (cnt == 4'd0) ? done_nxt : ST_WB;
            end
            ST_INTR: begin
`ifdef OTTER_INTR_EN
                INTR_TAKEN = 1'b1;
                PC_WRITE = 1'b1;
`endif
                nxt = ST_FETCH;
            end
            default: nxt = ST_INIT;
        endcase
    end
endmodule
